// File: rtl/dffram_arbiter_2p.sv
// Two-port arbiter in front of a single-port 2048x32 DFFRAM macro.
// It grants one request per cycle and returns the macro's registered read data to that port.
module dffram_arbiter_2p #(
    parameter int AW    = 11,
    parameter bit RR_EN = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,

    input  logic          p0_valid,
    output logic          p0_ready,
    input  logic          p0_lock,
    input  logic [3:0]    p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_rvalid,
    output logic [31:0]   p0_rdata,

    input  logic          p1_valid,
    output logic          p1_ready,
    input  logic          p1_lock,
    input  logic [3:0]    p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_rvalid,
    output logic [31:0]   p1_rdata,

    output logic          ram_EN,
    output logic [3:0]    ram_WE,
    output logic [AW-1:0] ram_A,
    output logic [31:0]   ram_Di,
    input  logic [31:0]   ram_Do
);

    logic rr_last;
    logic lock_owner_valid;
    logic lock_owner;
    logic rsp_valid;
    logic rsp_port;

    logic gnt_any;
    logic gnt_port;
    logic owner_req;
    logic gnt_lock;

    // Grant selection; reset masks every request so the macro stays idle.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_port  = 1'b0;
        owner_req = lock_owner ? p1_valid : p0_valid;
        if (!RST) begin
            if (lock_owner_valid && owner_req) begin
                gnt_any  = 1'b1;
                gnt_port = lock_owner;
            end else if (p0_valid && p1_valid) begin
                gnt_any  = 1'b1;
                gnt_port = RR_EN ? ~rr_last : 1'b0;
            end else if (p0_valid) begin
                gnt_any  = 1'b1;
                gnt_port = 1'b0;
            end else if (p1_valid) begin
                gnt_any  = 1'b1;
                gnt_port = 1'b1;
            end
        end
    end

    assign p0_ready = gnt_any & ~gnt_port;
    assign p1_ready = gnt_any &  gnt_port;
    assign gnt_lock = gnt_port ? p1_lock : p0_lock;

    // Macro drive: everything zero without a grant, so WE never appears without EN.
    always_comb begin
        ram_EN = 1'b0;
        ram_WE = 4'h0;
        ram_A  = '0;
        ram_Di = 32'h0;
        if (gnt_any) begin
            ram_EN = 1'b1;
            if (gnt_port) begin
                ram_WE = p1_we;
                ram_A  = p1_addr;
                ram_Di = p1_wdata;
            end else begin
                ram_WE = p0_we;
                ram_A  = p0_addr;
                ram_Di = p0_wdata;
            end
        end
    end

    // Control state; rsp_port and lock_owner are qualified by their valids and need no reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_last          <= 1'b1;
            lock_owner_valid <= 1'b0;
            rsp_valid        <= 1'b0;
        end else begin
            rsp_valid <= gnt_any;
            if (gnt_any) begin
                rr_last  <= gnt_port;
                rsp_port <= gnt_port;
            end
            if (gnt_any && gnt_lock) begin
                lock_owner_valid <= 1'b1;
                lock_owner       <= gnt_port;
            end else if (lock_owner_valid &&
                         (!owner_req || (gnt_any && gnt_port == lock_owner))) begin
                lock_owner_valid <= 1'b0;
            end
        end
    end

    // Response stage: the macro's registered output belongs to last cycle's grant.
    assign p0_rvalid = rsp_valid & ~rsp_port;
    assign p1_rvalid = rsp_valid &  rsp_port;
    assign p0_rdata  = p0_rvalid ? ram_Do : 32'h0;
    assign p1_rdata  = p1_rvalid ? ram_Do : 32'h0;

endmodule

// File: tb/tb_dffram_arbiter_2p.sv
// Directed bench for dffram_arbiter_2p: round-robin and fixed-priority instances,
// each backed by a read-before-write byte-masked RAM model.
module tb_dffram_arbiter_2p;

    localparam int AW = 11;

    logic          CLK = 1'b0;
    logic          RST;
    logic          p0_valid, p0_lock, p1_valid, p1_lock;
    logic [3:0]    p0_we, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [31:0]   p0_wdata, p1_wdata;

    logic          p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [31:0]   p0_rdata, p1_rdata;
    logic          ram_EN;
    logic [3:0]    ram_WE;
    logic [AW-1:0] ram_A;
    logic [31:0]   ram_Di, ram_Do;

    logic          fp_p0_ready, fp_p1_ready, fp_p0_rvalid, fp_p1_rvalid;
    logic [31:0]   fp_p0_rdata, fp_p1_rdata;
    logic          fp_ram_EN;
    logic [3:0]    fp_ram_WE;
    logic [AW-1:0] fp_ram_A;
    logic [31:0]   fp_ram_Di, fp_ram_Do;

    logic [31:0]   mem_a [0:2047];
    logic [31:0]   mem_b [0:2047];

    int n_vec = 0;
    int n_mis = 0;

    always #5 CLK = ~CLK;

    dffram_arbiter_2p #(.AW(AW), .RR_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_lock(p0_lock), .p0_we(p0_we),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_lock(p1_lock), .p1_we(p1_we),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_EN(ram_EN), .ram_WE(ram_WE), .ram_A(ram_A), .ram_Di(ram_Di), .ram_Do(ram_Do)
    );

    dffram_arbiter_2p #(.AW(AW), .RR_EN(1'b0)) dut_fp (
        .CLK(CLK), .RST(RST),
        .p0_valid(p0_valid), .p0_ready(fp_p0_ready), .p0_lock(p0_lock), .p0_we(p0_we),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(fp_p0_rvalid), .p0_rdata(fp_p0_rdata),
        .p1_valid(p1_valid), .p1_ready(fp_p1_ready), .p1_lock(p1_lock), .p1_we(p1_we),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(fp_p1_rvalid), .p1_rdata(fp_p1_rdata),
        .ram_EN(fp_ram_EN), .ram_WE(fp_ram_WE), .ram_A(fp_ram_A), .ram_Di(fp_ram_Di),
        .ram_Do(fp_ram_Do)
    );

    // Macro models: registered read of the old word, byte-masked write, 0 after an idle cycle.
    always @(posedge CLK) begin
        if (ram_EN) begin
            ram_Do <= mem_a[ram_A];
            for (int b = 0; b < 4; b++)
                if (ram_WE[b]) mem_a[ram_A][8*b +: 8] <= ram_Di[8*b +: 8];
        end else begin
            ram_Do <= 32'h0;
        end
    end

    always @(posedge CLK) begin
        if (fp_ram_EN) begin
            fp_ram_Do <= mem_b[fp_ram_A];
            for (int b = 0; b < 4; b++)
                if (fp_ram_WE[b]) mem_b[fp_ram_A][8*b +: 8] <= fp_ram_Di[8*b +: 8];
        end else begin
            fp_ram_Do <= 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        p0_valid = 1'b0; p0_lock = 1'b0; p0_we = 4'h0; p0_addr = '0; p0_wdata = 32'h0;
        p1_valid = 1'b0; p1_lock = 1'b0; p1_we = 4'h0; p1_addr = '0; p1_wdata = 32'h0;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        repeat (3) step();

        // Reset gates requests and clears responses
        p0_valid = 1'b1; p1_valid = 1'b1; p0_we = 4'hF;
        #1;
        chk("rst_p0_ready", p0_ready, 0);
        chk("rst_p1_ready", p1_ready, 0);
        chk("rst_ram_EN", ram_EN, 0);
        chk("rst_ram_WE", ram_WE, 0);
        step();
        chk("rst_p0_rvalid", p0_rvalid, 0);
        chk("rst_p1_rvalid", p1_rvalid, 0);
        RST = 1'b0;
        idle();

        // Port 0 full-word write then read back
        p0_valid = 1'b1; p0_we = 4'hF; p0_addr = 11'h005; p0_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_p0_ready", p0_ready, 1);
        chk("wr_p1_ready", p1_ready, 0);
        chk("wr_ram_EN", ram_EN, 1);
        chk("wr_ram_WE", ram_WE, 4'hF);
        chk("wr_ram_A", ram_A, 11'h005);
        chk("wr_ram_Di", ram_Di, 32'hDEADBEEF);
        step();
        chk("wr_p0_rvalid", p0_rvalid, 1);
        chk("wr_p1_rvalid", p1_rvalid, 0);
        p0_we = 4'h0;
        step();
        chk("rd_p0_rvalid", p0_rvalid, 1);
        chk("rd_p0_rdata", p0_rdata, 32'hDEADBEEF);
        chk("rd_p1_rvalid", p1_rvalid, 0);
        chk("rd_p1_rdata", p1_rdata, 32'h0);
        idle();
        #1;
        chk("idle_ram_EN", ram_EN, 0);
        chk("idle_ram_A", ram_A, 0);
        step();
        chk("idle_p0_rvalid", p0_rvalid, 0);
        chk("idle_p0_rdata", p0_rdata, 32'h0);

        // Port 1 byte-masked write returns the old word
        p1_valid = 1'b1; p1_we = 4'hF; p1_addr = 11'h010; p1_wdata = 32'h11223344;
        step();
        p1_we = 4'b0101; p1_wdata = 32'hAABBCCDD;
        step();
        chk("mask_p1_rvalid", p1_rvalid, 1);
        chk("mask_old_rdata", p1_rdata, 32'h11223344);
        p1_we = 4'h0;
        step();
        chk("mask_new_rdata", p1_rdata, 32'h11BB33DD);
        chk("mask_p0_rvalid", p0_rvalid, 0);
        idle();
        step();

        // Round-robin contention after reset: grants 0,1,0,1 (then one more 0)
        RST = 1'b1;
        step();
        RST = 1'b0;
        p0_valid = 1'b1; p0_addr = 11'h005;
        p1_valid = 1'b1; p1_addr = 11'h010;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rr%0d_p0_ready", i), p0_ready, (i % 2) == 0);
            chk($sformatf("rr%0d_p1_ready", i), p1_ready, (i % 2) == 1);
            chk($sformatf("rr%0d_ram_EN", i), ram_EN, 1);
            chk($sformatf("rr%0d_ram_A", i), ram_A, (i % 2) ? 11'h010 : 11'h005);
            if (i > 0) begin
                chk($sformatf("rr%0d_p0_rvalid", i), p0_rvalid, (i % 2) == 1);
                chk($sformatf("rr%0d_p1_rvalid", i), p1_rvalid, (i % 2) == 0);
                chk($sformatf("rr%0d_rdata", i), (i % 2) ? p0_rdata : p1_rdata,
                    (i % 2) ? 32'hDEADBEEF : 32'h11BB33DD);
            end
            step();
        end

        // Reset mid-traffic: port 0 was granted last, yet port 0 wins after release
        RST = 1'b1;
        #1;
        chk("mrst_p0_ready", p0_ready, 0);
        chk("mrst_p1_ready", p1_ready, 0);
        chk("mrst_ram_EN", ram_EN, 0);
        step();
        chk("mrst_p0_rvalid", p0_rvalid, 0);
        chk("mrst_p1_rvalid", p1_rvalid, 0);
        chk("mrst_ram_EN2", ram_EN, 0);
        step();
        RST = 1'b0;
        #1;
        chk("mrst_rel_p0_ready", p0_ready, 1);
        chk("mrst_rel_p1_ready", p1_ready, 0);
        step();

        // Fixed priority instance: port 0 wins every contended cycle
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("fp%0d_p0_ready", i), fp_p0_ready, 1);
            chk($sformatf("fp%0d_p1_ready", i), fp_p1_ready, 0);
            chk($sformatf("fp%0d_ram_EN", i), fp_ram_EN, 1);
            step();
        end
        idle();

        // Lock burst from port 1 while port 0 keeps requesting
        RST = 1'b1;
        step();
        RST = 1'b0;
        p0_valid = 1'b1; p0_addr = 11'h005;
        step();
        p1_valid = 1'b1; p1_lock = 1'b1; p1_we = 4'hF; p1_addr = 11'h7FD; p1_wdata = 32'h0000_0001;
        #1;
        chk("lk0_p1_ready", p1_ready, 1);
        chk("lk0_p0_ready", p0_ready, 0);
        chk("lk0_ram_A", ram_A, 11'h7FD);
        step();
        p1_addr = 11'h7FE; p1_wdata = 32'h0000_0002;
        #1;
        chk("lk1_p1_ready", p1_ready, 1);
        chk("lk1_p0_ready", p0_ready, 0);
        chk("lk1_p1_rvalid", p1_rvalid, 1);
        step();
        p1_lock = 1'b0; p1_addr = 11'h7FF; p1_wdata = 32'h0000_0003;
        #1;
        chk("lk2_p1_ready", p1_ready, 1);
        chk("lk2_p0_ready", p0_ready, 0);
        chk("lk2_ram_A", ram_A, 11'h7FF);
        step();
        p1_we = 4'h0;
        #1;
        chk("lk3_p0_ready", p0_ready, 1);
        chk("lk3_p1_ready", p1_ready, 0);
        chk("lk3_p1_rvalid", p1_rvalid, 1);
        step();
        chk("lk4_p0_rvalid", p0_rvalid, 1);
        chk("lk4_p0_rdata", p0_rdata, 32'hDEADBEEF);
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
